// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with split-transaction parking, resume re-grant and split timeout.
// All outputs are registered; grants always pass through IDLE between owners.
module bus_arbiter #(
    parameter logic        FIRST_PRIO    = 1'b0,
    parameter int unsigned SPLIT_TIMEOUT = 255,
    parameter int unsigned TOUT_W        = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic breq1,
    input  logic breq2,
    input  logic ssplit,
    input  logic split_resume,
    output logic bgrant1,
    output logic bgrant2,
    output logic msel,
    output logic msplit1,
    output logic msplit2,
    output logic split_grant,
    output logic split_abort
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn1 = 2'd1,
        StOwn2 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              split_pending_q, split_pending_d;
    logic              split_owner_q, split_owner_d;
    logic              resume_pend_q, resume_pend_d;
    logic [TOUT_W-1:0] tout_cnt_q, tout_cnt_d;
    logic              msplit1_q, msplit1_d;
    logic              msplit2_q, msplit2_d;
    logic              msel_q, msel_d;
    logic              split_grant_q, split_grant_d;
    logic              split_abort_q, split_abort_d;

    logic elig1, elig2, resume_req, counting, timeout_hit;

    assign elig1      = breq1 & ~msplit1_q;
    assign elig2      = breq2 & ~msplit2_q;
    assign resume_req = (split_resume | resume_pend_q) & split_pending_q;
    // A resume seen this cycle (or already latched) freezes the timeout.
    assign counting   = (SPLIT_TIMEOUT != 0) && split_pending_q && !resume_pend_q && !split_resume;
    assign timeout_hit = counting && (tout_cnt_q == TOUT_W'(SPLIT_TIMEOUT - 1));

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        split_pending_d = split_pending_q;
        split_owner_d   = split_owner_q;
        resume_pend_d   = resume_pend_q;
        tout_cnt_d      = tout_cnt_q;
        msplit1_d       = msplit1_q;
        msplit2_d       = msplit2_q;
        msel_d          = msel_q;
        split_grant_d   = 1'b0;
        split_abort_d   = 1'b0;

        if (timeout_hit) begin
            split_pending_d = 1'b0;
            msplit1_d       = 1'b0;
            msplit2_d       = 1'b0;
            tout_cnt_d      = '0;
            split_abort_d   = 1'b1;
        end else if (counting) begin
            tout_cnt_d = tout_cnt_q + 1'b1;
        end

        if (state_q != StIdle && split_resume && split_pending_q) begin
            resume_pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (resume_req) begin
                    state_d         = split_owner_q ? StOwn2 : StOwn1;
                    msel_d          = split_owner_q;
                    split_grant_d   = 1'b1;
                    split_pending_d = 1'b0;
                    resume_pend_d   = 1'b0;
                    msplit1_d       = 1'b0;
                    msplit2_d       = 1'b0;
                end else if (elig1 && elig2) begin
                    state_d = last_q ? StOwn1 : StOwn2;
                    msel_d  = ~last_q;
                    last_d  = ~last_q;
                end else if (elig1) begin
                    state_d = StOwn1;
                    msel_d  = 1'b0;
                    last_d  = 1'b0;
                end else if (elig2) begin
                    state_d = StOwn2;
                    msel_d  = 1'b1;
                    last_d  = 1'b1;
                end
            end
            StOwn1: begin
                // A split takes precedence over a simultaneous release.
                if (ssplit && !split_pending_q) begin
                    state_d         = StIdle;
                    split_pending_d = 1'b1;
                    split_owner_d   = 1'b0;
                    msplit1_d       = 1'b1;
                    tout_cnt_d      = '0;
                end else if (!breq1) begin
                    state_d = StIdle;
                end
            end
            StOwn2: begin
                if (ssplit && !split_pending_q) begin
                    state_d         = StIdle;
                    split_pending_d = 1'b1;
                    split_owner_d   = 1'b1;
                    msplit2_d       = 1'b1;
                    tout_cnt_d      = '0;
                end else if (!breq2) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= StIdle;
            last_q          <= ~FIRST_PRIO;
            split_pending_q <= 1'b0;
            split_owner_q   <= 1'b0;
            resume_pend_q   <= 1'b0;
            tout_cnt_q      <= '0;
            msplit1_q       <= 1'b0;
            msplit2_q       <= 1'b0;
            msel_q          <= 1'b0;
            split_grant_q   <= 1'b0;
            split_abort_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            split_pending_q <= split_pending_d;
            split_owner_q   <= split_owner_d;
            resume_pend_q   <= resume_pend_d;
            tout_cnt_q      <= tout_cnt_d;
            msplit1_q       <= msplit1_d;
            msplit2_q       <= msplit2_d;
            msel_q          <= msel_d;
            split_grant_q   <= split_grant_d;
            split_abort_q   <= split_abort_d;
        end
    end

    assign bgrant1     = (state_q == StOwn1);
    assign bgrant2     = (state_q == StOwn2);
    assign msel        = msel_q;
    assign msplit1     = msplit1_q;
    assign msplit2     = msplit2_q;
    assign split_grant = split_grant_q;
    assign split_abort = split_abort_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter: the driver queues hand-computed expected outputs,
// a separate monitor pops and compares them on the falling edge.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic breq1 = 1'b0, breq2 = 1'b0, ssplit = 1'b0, split_resume = 1'b0;
    logic bgrant1, bgrant2, msel, msplit1, msplit2, split_grant, split_abort;

    int   errors = 0;
    int   checks = 0;
    int   vec_no = 0;
    logic [6:0] exp_q [$];
    int         idx_q [$];

    always #5 clk = ~clk;

    bus_arbiter #(
        .FIRST_PRIO   (1'b0),
        .SPLIT_TIMEOUT(4),
        .TOUT_W       (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .breq1       (breq1),
        .breq2       (breq2),
        .ssplit      (ssplit),
        .split_resume(split_resume),
        .bgrant1     (bgrant1),
        .bgrant2     (bgrant2),
        .msel        (msel),
        .msplit1     (msplit1),
        .msplit2     (msplit2),
        .split_grant (split_grant),
        .split_abort (split_abort)
    );

    // in  = {rstn, breq1, breq2, ssplit, split_resume}
    // exp = {bgrant1, bgrant2, msel, msplit1, msplit2, split_grant, split_abort} after the edge
    task automatic step(input logic [4:0] in, input logic [6:0] exp);
        @(negedge clk);
        {rstn, breq1, breq2, ssplit, split_resume} = in;
        @(posedge clk);
        exp_q.push_back(exp);
        idx_q.push_back(vec_no);
        vec_no++;
    endtask

    initial begin : monitor
        logic [6:0] act, exp;
        int idx;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                idx = idx_q.pop_front();
                act = {bgrant1, bgrant2, msel, msplit1, msplit2, split_grant, split_abort};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL vec%0d {g1,g2,msel,ms1,ms2,sg,sa}: got %b expected %b",
                             idx, act, exp);
                end
            end
        end
    end

    initial begin : driver
        // Reset, single request on M1, release
        step(5'b00000, 7'b0000000);
        step(5'b10000, 7'b0000000);
        step(5'b11000, 7'b1000000);
        step(5'b11000, 7'b1000000);
        step(5'b11000, 7'b1000000);
        step(5'b10000, 7'b0000000);
        // Tie after reset -> M1, then M2 after one idle, next tie -> M1
        step(5'b00000, 7'b0000000);
        step(5'b11100, 7'b1000000);
        step(5'b11100, 7'b1000000);
        step(5'b10100, 7'b0000000);
        step(5'b10100, 7'b0110000);
        step(5'b10100, 7'b0110000);
        step(5'b10000, 7'b0010000);
        step(5'b11100, 7'b1000000);
        step(5'b10100, 7'b0000000);
        step(5'b10100, 7'b0110000);
        // M2 split, M1 served, resume latched during M1, M2 re-granted with split_grant
        step(5'b11110, 7'b0010100);
        step(5'b11100, 7'b1000100);
        step(5'b11101, 7'b1000100);
        step(5'b10100, 7'b0000100);
        step(5'b10100, 7'b0110010);
        step(5'b10100, 7'b0110000);
        step(5'b10000, 7'b0010000);
        // M1 split, no resume: parked for 4 cycles, abort pulse, then normal re-arbitration
        step(5'b11000, 7'b1000000);
        step(5'b11010, 7'b0001000);
        step(5'b11000, 7'b0001000);
        step(5'b11000, 7'b0001000);
        step(5'b11000, 7'b0001000);
        step(5'b11000, 7'b0000001);
        step(5'b11000, 7'b1000000);
        step(5'b10000, 7'b0000000);
        // Second ssplit while pending is ignored; resume then re-grants M1
        step(5'b11000, 7'b1000000);
        step(5'b11010, 7'b0001000);
        step(5'b11100, 7'b0111000);
        step(5'b11110, 7'b0111000);
        step(5'b11101, 7'b0111000);
        step(5'b11000, 7'b0011000);
        step(5'b11000, 7'b1000010);
        step(5'b10000, 7'b0000000);
        // Resume with nothing pending has no effect
        step(5'b10001, 7'b0000000);
        step(5'b10000, 7'b0000000);
        // Reset during OWN2 with a split pending, then a fresh grant
        step(5'b11000, 7'b1000000);
        step(5'b11010, 7'b0001000);
        step(5'b11100, 7'b0111000);
        step(5'b01100, 7'b0000000);
        step(5'b10100, 7'b0110000);
        step(5'b10000, 7'b0010000);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
